core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control sequencer for the NPC core. It steps the combinational datapath and decoder through fetch, execute, memory and writeback. It handshakes with the instruction-fetch and load/store memory ports. It gates the decoder's register-write, memory-request and PC-update strobes so each one fires exactly once per instruction, and it halts the core on `ebreak` or on a memory timeout.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `TIMEOUT`, default 255: maximum wait cycles on one memory request before error; valid range 1..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  out  32  current instruction address; also drives the fetch address.
- `next_pc`  in  32  next PC from the branch/jump logic; valid in EXEC and WB.
- `ifu_req`  out  1  fetch request.
- `ifu_ready`  in  1  fetch complete; `ifu_rdata` is valid in the same cycle.
- `ifu_rdata`  in  32  fetched instruction word.
- `inst`  out  32  instruction register; feeds the decoder.
- `ctl_RegWr`  in  1  decoder register-write control.
- `ctl_MemtoReg`  in  1  decoder load control.
- `ctl_MemWr`  in  1  decoder store control.
- `is_ebreak`  in  1  decoder flag for the `ebreak` instruction.
- `lsu_req`  out  1  data-memory request.
- `lsu_we`  out  1  data-memory write enable; valid while `lsu_req`=1.
- `lsu_ready`  in  1  data access complete.
- `rf_we`  out  1  register-file write strobe.
- `halt`  out  1  core stopped.
- `err`  out  1  stop caused by timeout.
- `retired`  out  32  count of retired instructions.

## Operation
- States: BOOT, FETCH, EXEC, MEM, WB, HALT. Encoding is free; all outputs except the registers are Moore decodes of the state.
- Reset (`rst`=1 at an edge, from any state, including mid-handshake):
  - state←BOOT; `pc`←RESET_PC; `inst`←0; `retired`←0; wait counter←0; `err`←0.
  - Outputs while in BOOT: `ifu_req`=`lsu_req`=`lsu_we`=`rf_we`=`halt`=0.
- BOOT → FETCH unconditionally.
- FETCH:
  - `ifu_req`=1.
  - On an edge with `ifu_ready`=1: `inst`←`ifu_rdata`, wait counter←0, state→EXEC.
  - Otherwise wait counter increments.
- EXEC: one cycle; the decoder evaluates `inst`. Transitions, in priority order:
  - `is_ebreak`=1 → HALT with `err`=0; `retired` increments, because `ebreak` counts as retired.
  - `ctl_MemtoReg`|`ctl_MemWr` → MEM.
  - Otherwise → WB.
- MEM:
  - `lsu_req`=1; `lsu_we`=`ctl_MemWr`.
  - On an edge with `lsu_ready`=1: wait counter←0, state→WB.
  - Otherwise wait counter increments.
- WB: one cycle.
  - `rf_we`=`ctl_RegWr`.
  - At the edge: `pc`←`next_pc`, `retired`←`retired`+1 (wraps modulo 2^32), state→FETCH.
- HALT: absorbing until reset.
  - `halt`=1; all requests and strobes are 0; `pc` and `retired` are frozen.
- Timeout: in FETCH or MEM, if the wait counter equals TIMEOUT and ready=0 at an edge → HALT with `err`←1. `inst` and `pc` are unchanged.
- Ready sampled outside its matching request state is ignored.
- The load-data register in the LSU holds its value through WB; the sequencer does not capture data.

## Timing
- Request protocol: once `ifu_req` or `lsu_req` rises, it stays high until the edge at which the matching ready is sampled high. Completion and the state change happen on that same edge, and the request drops in the next cycle. Back-to-back requests are always separated by at least one cycle with the request low.
- Per-instruction latency with zero-wait memories:
  - ALU/branch: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles.
  - Each wait cycle adds 1.
- First fetch: `ifu_req` is high in the 2nd cycle after `rst` deasserts.
- `rf_we` is high for exactly one cycle per instruction, and only when `ctl_RegWr`=1.
- Timeout detection: the maximum wait is TIMEOUT+1 cycles in the request state; `halt` and `err` rise in the cycle after that.
- `next_pc` and all `ctl_*` inputs must be stable from EXEC through WB; they derive only from `inst` and the register file.

## Test plan
- Reset, then `ifu_ready`=1 every cycle with `addi` (`ctl_RegWr`=1, no mem) and `next_pc`=`pc`+4 → `pc` goes 8000_0000, 8000_0004, 8000_0008 every 3 cycles; `rf_we` pulses once per instruction; `retired`=3 after 9 cycles past BOOT.
- Load with `ifu_ready`/`lsu_ready` delayed 2 cycles each → `lsu_req` high for 3 cycles with `lsu_we`=0; `rf_we` pulses once in WB; total 8 cycles. Store (`ctl_MemWr`=1, `ctl_RegWr`=0) → `lsu_we`=1 and no `rf_we` pulse.
- `ebreak` fetched as the 5th instruction → `halt`=1, `err`=0, `retired`=5. Further `ifu_ready` pulses leave `pc` and `retired` frozen.
- TIMEOUT=4 with `lsu_ready` held 0 → `lsu_req` high 5 cycles, then `halt`=`err`=1; `rf_we` never pulses.
- `rst` asserted for 1 cycle mid-MEM with `lsu_ready` arriving in the same cycle → next state BOOT, `pc`=8000_0000, `retired`=0, no `rf_we` pulse, `lsu_req` low the following cycle.
- Spurious `lsu_ready` pulse during FETCH and EXEC → ignored; the subsequent MEM phase still waits for its own `lsu_ready`.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/exec/mem/writeback control with memory handshakes, timeout and halt
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic        ifu_req,
  input  logic        ifu_ready,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        ctl_RegWr,
  input  logic        ctl_MemtoReg,
  input  logic        ctl_MemWr,
  input  logic        is_ebreak,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_ready,
  output logic        rf_we,
  output logic        halt,
  output logic        err,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {BOOT, FETCH, EXEC, MEM, WB, HALT} state_t;
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  state_t      state_q;
  logic [31:0] pc_q, inst_q, retired_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic        rdy;
  assign rdy = (state_q == FETCH) ? ifu_ready : lsu_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= FETCH;
        FETCH, MEM: begin
          if (rdy) begin
            cnt_q   <= '0;
            state_q <= (state_q == FETCH) ? EXEC : WB;
            if (state_q == FETCH) inst_q <= ifu_rdata;
          end else if (cnt_q == TMO) begin
            state_q <= HALT;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        EXEC: begin
          state_q   <= is_ebreak ? HALT : (ctl_MemtoReg | ctl_MemWr) ? MEM : WB;
          retired_q <= retired_q + {31'd0, is_ebreak};
        end
        WB: begin
          pc_q      <= next_pc;
          retired_q <= retired_q + 32'd1;
          state_q   <= FETCH;
        end
        HALT: ;
        default: state_q <= BOOT;
      endcase
    end
  end
  assign pc      = pc_q;
  assign inst    = inst_q;
  assign retired = retired_q;
  assign err     = err_q;
  assign ifu_req = state_q == FETCH;
  assign lsu_req = state_q == MEM;
  assign lsu_we  = (state_q == MEM) & ctl_MemWr;
  assign rf_we   = (state_q == WB) & ctl_RegWr;
  assign halt    = state_q == HALT;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: per-cycle vector table plus hand-written ALU-run and ebreak sequences
module tb_core_sequencer;
  localparam logic [31:0] P = 32'h8000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc, next_pc, ifu_rdata = '0, inst, retired;
  logic ifu_req, ifu_ready = 0, ctl_RegWr = 0, ctl_MemtoReg = 0, ctl_MemWr = 0, is_ebreak = 0;
  logic lsu_req, lsu_we, lsu_ready = 0, rf_we, halt, err;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign next_pc = pc + 32'd4;
  core_sequencer #(.RESET_PC(P), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .ifu_req(ifu_req), .ifu_ready(ifu_ready),
    .ifu_rdata(ifu_rdata), .inst(inst), .ctl_RegWr(ctl_RegWr), .ctl_MemtoReg(ctl_MemtoReg),
    .ctl_MemWr(ctl_MemWr), .is_ebreak(is_ebreak), .lsu_req(lsu_req), .lsu_we(lsu_we),
    .lsu_ready(lsu_ready), .rf_we(rf_we), .halt(halt), .err(err), .retired(retired)
  );
  // di = {rst, ifu_ready, lsu_ready, RegWr, MemtoReg, MemWr, ebreak}; dout = {ifu_req, lsu_req, lsu_we, rf_we, halt, err}
  typedef struct packed {
    logic [6:0]  di;
    logic [5:0]  dout;
    logic [31:0] pc_e, ret_e;
    logic [7:0]  ins;
  } vec_t;
  vec_t q[$];
  task automatic add(input logic [6:0] di, input logic [5:0] dout, input logic [31:0] pc_e, ret_e, input logic [7:0] ins, input int n = 1);
    for (int k = 0; k < n; k++) q.push_back('{di, dout, pc_e, ret_e, ins});
  endtask
  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int rfc, n;
    add(7'b1000000, 6'b000000, P, 0, 0);
    add(7'b0000000, 6'b000000, P, 0, 0);
    add(7'b0100000, 6'b100000, P, 0, 0);
    add(7'b0001000, 6'b000000, P, 0, 2);
    add(7'b0001000, 6'b000100, P, 0, 2);
    add(7'b0100000, 6'b100000, P + 4, 1, 2);
    add(7'b0001000, 6'b000000, P + 4, 1, 5);
    add(7'b0001000, 6'b000100, P + 4, 1, 5);
    add(7'b0100000, 6'b100000, P + 8, 2, 5);
    add(7'b0001000, 6'b000000, P + 8, 2, 8);
    add(7'b0001000, 6'b000100, P + 8, 2, 8);
    add(7'b0000000, 6'b100000, P + 12, 3, 8, 2);
    add(7'b0100000, 6'b100000, P + 12, 3, 8);
    add(7'b0001100, 6'b000000, P + 12, 3, 13);
    add(7'b0001100, 6'b010000, P + 12, 3, 13, 2);
    add(7'b0011100, 6'b010000, P + 12, 3, 13);
    add(7'b0001100, 6'b000100, P + 12, 3, 13);
    add(7'b0100000, 6'b100000, P + 16, 4, 13);
    add(7'b0000001, 6'b000000, P + 16, 4, 19);
    add(7'b0110000, 6'b000010, P + 16, 5, 19);
    add(7'b0100000, 6'b000010, P + 16, 5, 19);
    add(7'b1000000, 6'b000010, P + 16, 5, 19);
    add(7'b0000000, 6'b000000, P, 0, 0);
    add(7'b0010000, 6'b100000, P, 0, 0);
    add(7'b0110000, 6'b100000, P, 0, 0);
    add(7'b0010010, 6'b000000, P, 0, 26);
    add(7'b0000010, 6'b011000, P, 0, 26);
    add(7'b0010010, 6'b011000, P, 0, 26);
    add(7'b0000010, 6'b000000, P, 0, 26);
    add(7'b0100000, 6'b100000, P + 4, 1, 26);
    add(7'b0001100, 6'b000000, P + 4, 1, 31);
    add(7'b0001100, 6'b010000, P + 4, 1, 31, 5);
    add(7'b0000000, 6'b000011, P + 4, 1, 31);
    add(7'b0110000, 6'b000011, P + 4, 1, 31);
    add(7'b1000000, 6'b000011, P + 4, 1, 31);
    add(7'b0000000, 6'b000000, P, 0, 0);
    add(7'b0100000, 6'b100000, P, 0, 0);
    add(7'b0001100, 6'b000000, P, 0, 42);
    add(7'b1011100, 6'b010000, P, 0, 42);
    add(7'b0000000, 6'b000000, P, 0, 0);
    add(7'b0000000, 6'b100000, P, 0, 0, 5);
    add(7'b0000000, 6'b000011, P, 0, 0);
    tick();
    foreach (q[i]) begin
      {rst, ifu_ready, lsu_ready, ctl_RegWr, ctl_MemtoReg, ctl_MemWr, is_ebreak} = q[i].di;
      ifu_rdata = 32'hC0DE_0000 | i;
      @(negedge clk);
      check("outs", i, {26'd0, ifu_req, lsu_req, lsu_we, rf_we, halt, err}, {26'd0, q[i].dout});
      check("pc", i, pc, q[i].pc_e);
      check("retired", i, retired, q[i].ret_e);
      check("inst", i, inst, (q[i].ins == 0) ? 32'd0 : (32'hC0DE_0000 | 32'(q[i].ins)));
      tick();
    end
    {rst, ifu_ready, lsu_ready, ctl_RegWr, ctl_MemtoReg, ctl_MemWr, is_ebreak} = 7'b1000000;
    tick();
    rst = 0;
    ifu_ready = 1;
    ctl_RegWr = 1;
    rfc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rfc += int'(rf_we);
      tick();
    end
    check("alu_retired", 100, retired, 3);
    check("alu_pc", 100, pc, P + 12);
    check("alu_rf_pulses", 100, rfc, 3);
    ctl_RegWr = 0;
    is_ebreak = 1;
    n = 0;
    while (!halt && n < 20) begin
      tick();
      n++;
    end
    check("ebreak_halt", 101, {31'd0, halt}, 1);
    check("ebreak_err", 101, {31'd0, err}, 0);
    check("ebreak_retired", 101, retired, 4);
    repeat (3) tick();
    check("frozen_pc", 102, pc, P + 12);
    check("frozen_retired", 102, retired, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
